scr1_dmem_mbox: RTL and testbench
=================================

Name: scr1_dmem_mbox

Overview:
- Memory-mapped mailbox slave on one data-memory router port, typically port3 at 0x0003_0000.
- Core stores words into a TX FIFO that drains to an accelerator stream.
- Core loads accelerator results from an RX FIFO filled by the accelerator stream.
- Gives crypto/AI accelerators a decoupled, back-pressured path to the SCR1 core.

Parameters:
- MBOX_DEPTH, default 8: entries per FIFO; power of two, range 2..64.
- MBOX_CNT_W, default $clog2(MBOX_DEPTH)+1: width of the occupancy counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- dmem_req_ack  out  1  request accepted; constant 1
- dmem_req  in  1  request valid
- dmem_cmd  in  type_scr1_mem_cmd_e  read/write
- dmem_width  in  type_scr1_mem_width_e  access width
- dmem_addr  in  SCR1_DMEM_AWIDTH  byte address; only addr[3:0] decoded
- dmem_wdata  in  SCR1_DMEM_DWIDTH  write data
- dmem_rdata  out  SCR1_DMEM_DWIDTH  read data
- dmem_resp  out  type_scr1_mem_resp_e  response
- tx_vld  out  1  TX FIFO head valid
- tx_rdy  in  1  accelerator takes head
- tx_data  out  32  TX FIFO head
- rx_vld  in  1  accelerator result valid
- rx_rdy  out  1  RX FIFO not full
- rx_data  in  32  accelerator result
- irq  out  1  mailbox interrupt (see Optional Feature)

Behaviour:
- Register map (addr[3:2]):
  - 0x0 TXDATA: W pushes wdata; R is an error.
  - 0x4 RXDATA: R pops head; W is an error.
  - 0x8 STATUS: R-only. Bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, [15:8] tx_count, [23:16] rx_count, zero-extended.
  - 0xC CTRL: bit0 flush_tx (W1, self-clearing), bit1 flush_rx (W1, self-clearing), bit2 irq_en (R/W). Reads return {29'b0, irq_en, 2'b0}.
- Handshake:
  - dmem_req_ack=1 always.
  - A request is accepted in cycle N when dmem_req=1.
  - dmem_resp is RDY_OK or RDY_ER in cycle N+1. Otherwise it is NOTRDY.
  - Back-to-back accepts are allowed: a new request may be accepted in the same cycle a response is presented.
- Response state: one registered stage holding resp_vld, resp_err and rdata. No other FSM.
- Side effects occur at the accept edge. Decisions use FIFO state sampled in cycle N, before stream activity in that cycle.
- Errors (RDY_ER, rdata=0, no side effect):
  - width not WORD
  - addr[1:0]!=0
  - write to TXDATA while tx_full
  - read of RXDATA while rx_empty
  - write to RXDATA or STATUS
  - read of TXDATA
- RDY_OK read data: rdata = register value for STATUS/CTRL, or the popped RX head for RXDATA.
- Writes return rdata=0.
- FIFOs: circular pointers wrap at MBOX_DEPTH; count range 0..MBOX_DEPTH.
  - tx_vld = !tx_empty; tx_data = TX head.
  - rx_rdy = !rx_full.
- Simultaneous events:
  - Core push and stream pop on the same FIFO in the same cycle: count unchanged, both succeed. The core push is never refused because a pop occurs in the same cycle; the full check uses cycle-N state.
  - Flush and stream push/pop in the same cycle: flush wins, count=0, the stream-side transfer is discarded.
- Reset (async, any time, including with a response pending): FIFOs empty, pointers 0, irq_en=0, dmem_resp=NOTRDY, dmem_rdata=0, tx_vld=0, rx_rdy=1, irq=0. A pending response is dropped.
- Assertion under SCR1_TRGT_SIMULATION: no X on {dmem_cmd, dmem_width, dmem_addr[3:0]} while dmem_req.

Optional Feature:
- Macro: SCR1_MBOX_IRQ_EN.
- Defined: irq is registered and equals irq_en & !rx_empty, updating one cycle after the condition changes.
- Undefined: irq tied 0; irq_en bit still R/W and has no effect.

Decomposition:
- Package scr1_mbox_pkg:
  - register offset localparams (SCR1_MBOX_OFS_TXDATA/RXDATA/STATUS/CTRL)
  - STATUS and CTRL bit-position constants
  - enum type_scr1_mbox_reg_e
- Memory command/width/response enums come from scr1_memif.svh.
- One sub-module: scr1_mbox_fifo (parameterised sync FIFO), instantiated twice.
  - Ports: push, pop, flush, wdata, rdata, full, empty, count.

Test Plan:
- Write 0xA5A5_0001 to offset 0x0 with tx_rdy=0 -> RDY_OK next cycle; tx_vld=1, tx_data=0xA5A5_0001; STATUS[15:8]=1.
- Write 9 words to TXDATA, tx_rdy=0, MBOX_DEPTH=8 -> first 8 RDY_OK, 9th RDY_ER; tx_count=8, tx_full=1. Then tx_rdy=1 for one cycle -> tx_count=7.
- Read RXDATA while empty -> RDY_ER, rdata=0. Drive rx_data=0x1234_5678 for one cycle, then read -> RDY_OK, rdata=0x1234_5678, rx_empty=1 afterwards.
- Back-to-back requests on consecutive cycles: STATUS read then TXDATA write -> responses in consecutive cycles, both RDY_OK, no NOTRDY bubble.
- Byte write to offset 0x0 and word access at addr 0x2 -> both RDY_ER, FIFO unchanged. CTRL write 0x3 with rx_vld=1 in the same cycle -> both counts 0.
- With SCR1_MBOX_IRQ_EN: CTRL=0x4, push one RX word -> irq=1 one cycle later. Pop it -> irq=0. Assert rst_n low with a response pending -> resp=NOTRDY immediately.

Source files
------------

// File: rtl/scr1_dmem_mbox_pkg.sv
// Mailbox package: memory interface types, register map and bit positions
// shared by the mailbox interface, FIFO and top level.
package scr1_mbox_pkg;

  // Data-memory bus widths and command/width/response encodings (same
  // values as the SCR1 memory interface definitions)
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Register byte offsets inside the mailbox window
  localparam logic [3:0] SCR1_MBOX_OFS_TXDATA = 4'h0;
  localparam logic [3:0] SCR1_MBOX_OFS_RXDATA = 4'h4;
  localparam logic [3:0] SCR1_MBOX_OFS_STATUS = 4'h8;
  localparam logic [3:0] SCR1_MBOX_OFS_CTRL   = 4'hC;

  // Register select decoded from addr[3:2]
  typedef enum logic [1:0] {
    SCR1_MBOX_REG_TXDATA = SCR1_MBOX_OFS_TXDATA[3:2],
    SCR1_MBOX_REG_RXDATA = SCR1_MBOX_OFS_RXDATA[3:2],
    SCR1_MBOX_REG_STATUS = SCR1_MBOX_OFS_STATUS[3:2],
    SCR1_MBOX_REG_CTRL   = SCR1_MBOX_OFS_CTRL[3:2]
  } type_scr1_mbox_reg_e;

  // STATUS bit positions
  localparam int SCR1_MBOX_STATUS_TX_FULL  = 0;
  localparam int SCR1_MBOX_STATUS_TX_EMPTY = 1;
  localparam int SCR1_MBOX_STATUS_RX_FULL  = 2;
  localparam int SCR1_MBOX_STATUS_RX_EMPTY = 3;
  localparam int SCR1_MBOX_STATUS_TX_CNT   = 8;
  localparam int SCR1_MBOX_STATUS_RX_CNT   = 16;

  // CTRL bit positions
  localparam int SCR1_MBOX_CTRL_FLUSH_TX = 0;
  localparam int SCR1_MBOX_CTRL_FLUSH_RX = 1;
  localparam int SCR1_MBOX_CTRL_IRQ_EN   = 2;

  // Map a byte address onto the register it selects
  function automatic type_scr1_mbox_reg_e scr1_mbox_decode(input logic [3:0] addr);
    return type_scr1_mbox_reg_e'(addr[3:2]);
  endfunction

endpackage

// File: rtl/scr1_dmem_mbox_if.sv
// Data-memory request/response bundle between the router port (master)
// and the mailbox (slave).
interface scr1_dmem_mbox_if;
  import scr1_mbox_pkg::*;

  logic                        dmem_req_ack;
  logic                        dmem_req;
  type_scr1_mem_cmd_e          dmem_cmd;
  type_scr1_mem_width_e        dmem_width;
  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr;
  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata;
  logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata;
  type_scr1_mem_resp_e         dmem_resp;

  modport master (
    input  dmem_req_ack, dmem_rdata, dmem_resp,
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata
  );

  modport slave (
    output dmem_req_ack, dmem_rdata, dmem_resp,
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata
  );

endinterface

// File: rtl/scr1_dmem_mbox_fifo.sv
// Synchronous circular FIFO used for both mailbox directions.
// Flush has priority over any push/pop in the same cycle.
module scr1_mbox_fifo #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q;
  logic [PTR_W-1:0]  rdPtr_q;
  logic [CNT_W-1:0]  count_q;
  logic              doPush;
  logic              doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  assign doPush = push_i & ~full_o & ~flush_i;
  assign doPop  = pop_i & ~empty_o & ~flush_i;

  // Storage array: written at the tail on every accepted push
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/scr1_dmem_mbox.sv
// Memory-mapped mailbox slave: core writes TXDATA to feed an accelerator
// stream and reads RXDATA to collect its results. One registered response
// stage gives a fixed one-cycle response latency with back-to-back accepts.
// Optional feature macro: SCR1_MBOX_IRQ_EN (registered RX-not-empty irq).
module scr1_dmem_mbox
  import scr1_mbox_pkg::*;
#(
  parameter int MBOX_DEPTH = 8,
  parameter int MBOX_CNT_W = $clog2(MBOX_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scr1_dmem_mbox_if.slave       dmem,
  output logic                  tx_vld_o,
  input  logic                  tx_rdy_i,
  output logic [31:0]           tx_data_o,
  input  logic                  rx_vld_i,
  output logic                  rx_rdy_o,
  input  logic [31:0]           rx_data_i,
  output logic                  irq_o
);

  logic                        txFull, txEmpty, rxFull, rxEmpty;
  logic [MBOX_CNT_W-1:0]       txCount, rxCount;
  logic [31:0]                 rxHead;
  logic                        txPush, txPop, rxPush, rxPop;
  logic                        flushTx, flushRx;
  logic                        reqErr;
  logic                        isWr;
  type_scr1_mbox_reg_e         regSel;
  logic [31:0]                 statusWord;
  logic [31:0]                 ctrlWord;
  logic [SCR1_DMEM_DWIDTH-1:0] rdata_d, rdata_q;
  logic                        respVld_q, respErr_q;
  logic                        irqEn_d, irqEn_q;
  logic                        unusedAddr;

  assign unusedAddr = ^dmem.dmem_addr[SCR1_DMEM_AWIDTH-1:4];

  assign isWr   = (dmem.dmem_cmd == SCR1_MEM_CMD_WR);
  assign regSel = scr1_mbox_decode(dmem.dmem_addr[3:0]);

  assign statusWord = (32'(txFull)  << SCR1_MBOX_STATUS_TX_FULL)
                    | (32'(txEmpty) << SCR1_MBOX_STATUS_TX_EMPTY)
                    | (32'(rxFull)  << SCR1_MBOX_STATUS_RX_FULL)
                    | (32'(rxEmpty) << SCR1_MBOX_STATUS_RX_EMPTY)
                    | (32'(8'(txCount)) << SCR1_MBOX_STATUS_TX_CNT)
                    | (32'(8'(rxCount)) << SCR1_MBOX_STATUS_RX_CNT);
  assign ctrlWord   = 32'(irqEn_q) << SCR1_MBOX_CTRL_IRQ_EN;

  // Decode the request against FIFO state of this cycle: errors, side
  // effects and the read data for next cycle's response
  always_comb begin
    reqErr  = 1'b0;
    rdata_d = '0;
    txPush  = 1'b0;
    rxPop   = 1'b0;
    flushTx = 1'b0;
    flushRx = 1'b0;
    irqEn_d = irqEn_q;
    if (dmem.dmem_req) begin
      if ((dmem.dmem_width != SCR1_MEM_WIDTH_WORD) || (dmem.dmem_addr[1:0] != 2'b00)) begin
        reqErr = 1'b1;
      end else begin
        case (regSel)
          SCR1_MBOX_REG_TXDATA: begin
            if (!isWr || txFull) reqErr = 1'b1;
            else                 txPush = 1'b1;
          end
          SCR1_MBOX_REG_RXDATA: begin
            if (isWr || rxEmpty) begin
              reqErr = 1'b1;
            end else begin
              rxPop   = 1'b1;
              rdata_d = rxHead;
            end
          end
          SCR1_MBOX_REG_STATUS: begin
            if (isWr) reqErr  = 1'b1;
            else      rdata_d = statusWord;
          end
          SCR1_MBOX_REG_CTRL: begin
            if (isWr) begin
              flushTx = dmem.dmem_wdata[SCR1_MBOX_CTRL_FLUSH_TX];
              flushRx = dmem.dmem_wdata[SCR1_MBOX_CTRL_FLUSH_RX];
              irqEn_d = dmem.dmem_wdata[SCR1_MBOX_CTRL_IRQ_EN];
            end else begin
              rdata_d = ctrlWord;
            end
          end
        endcase
      end
    end
  end

  // Response stage and the irq enable bit; reset drops any pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      respVld_q <= 1'b0;
      respErr_q <= 1'b0;
      rdata_q   <= '0;
      irqEn_q   <= 1'b0;
    end else begin
      respVld_q <= dmem.dmem_req;
      respErr_q <= reqErr;
      rdata_q   <= rdata_d;
      irqEn_q   <= irqEn_d;
    end
  end

  assign dmem.dmem_req_ack = 1'b1;
  assign dmem.dmem_rdata   = rdata_q;
  assign dmem.dmem_resp    = !respVld_q ? SCR1_MEM_RESP_NOTRDY :
                             respErr_q  ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;

  assign tx_vld_o = ~txEmpty;
  assign txPop    = ~txEmpty & tx_rdy_i;
  assign rx_rdy_o = ~rxFull;
  assign rxPush   = rx_vld_i & ~rxFull;

  scr1_mbox_fifo #(
    .DEPTH  (MBOX_DEPTH),
    .CNT_W  (MBOX_CNT_W),
    .DATA_W (32)
  ) txFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (txPush),
    .pop_i   (txPop),
    .flush_i (flushTx),
    .wdata_i (dmem.dmem_wdata),
    .rdata_o (tx_data_o),
    .full_o  (txFull),
    .empty_o (txEmpty),
    .count_o (txCount)
  );

  scr1_mbox_fifo #(
    .DEPTH  (MBOX_DEPTH),
    .CNT_W  (MBOX_CNT_W),
    .DATA_W (32)
  ) rxFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rxPush),
    .pop_i   (rxPop),
    .flush_i (flushRx),
    .wdata_i (rx_data_i),
    .rdata_o (rxHead),
    .full_o  (rxFull),
    .empty_o (rxEmpty),
    .count_o (rxCount)
  );

`ifdef SCR1_MBOX_IRQ_EN
  logic irq_q;

  // Interrupt raised one cycle after RX holds data while irq is enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irqEn_q & ~rxEmpty;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

`ifdef SCR1_TRGT_SIMULATION
  // Request qualifiers must be known whenever a request is presented
  assert property (@(posedge clk) disable iff (!rst_n)
    dmem.dmem_req |-> !$isunknown({dmem.dmem_cmd, dmem.dmem_width, dmem.dmem_addr[3:0]}));
`endif

endmodule

// File: tb/tb_scr1_dmem_mbox.sv
// Randomised scoreboard bench for the data-memory mailbox. Responses are
// predicted by a queue-based model of both FIFOs and checked by a monitor.
module tb_scr1_dmem_mbox;
  import scr1_mbox_pkg::*;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        txVld, txRdy, rxVld, rxRdy, irq;
  logic [31:0] txData, rxData;

  scr1_dmem_mbox_if mboxIf();

  scr1_dmem_mbox #(.MBOX_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dmem      (mboxIf.slave),
    .tx_vld_o  (txVld),
    .tx_rdy_i  (txRdy),
    .tx_data_o (txData),
    .rx_vld_i  (rxVld),
    .rx_rdy_o  (rxRdy),
    .rx_data_i (rxData),
    .irq_o     (irq)
  );

  int          checkCount = 0;
  int          errorCount = 0;

  // Reference model state
  logic [31:0] txQ[$];
  logic [31:0] rxQ[$];
  bit          irqEnModel = 0;
  bit          prevIrqCond = 0;
  // Scoreboard of expected responses
  bit          expErrQ[$];
  logic [31:0] expRdataQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream-side and irq outputs must reflect the model state after the last edge
  task automatic checkOutput();
    logic expIrq;
`ifdef SCR1_MBOX_IRQ_EN
    expIrq = prevIrqCond;
`else
    expIrq = 1'b0;
`endif
    checkVal("req_ack", 32'(mboxIf.dmem_req_ack), 32'd1);
    checkVal("tx_vld", 32'(txVld), 32'(txQ.size() > 0));
    if (txQ.size() > 0) checkVal("tx_data", txData, txQ[0]);
    checkVal("rx_rdy", 32'(rxRdy), 32'(rxQ.size() < DEPTH));
    checkVal("irq", 32'(irq), 32'(expIrq));
    prevIrqCond = irqEnModel && (rxQ.size() > 0);
  endtask

  // Predict the response and the FIFO contents after the coming clock edge
  task automatic modelStep(input logic req, input type_scr1_mem_cmd_e cmd,
                           input type_scr1_mem_width_e width, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic txRdyIn, input logic rxVldIn,
                           input logic [31:0] rxDataIn);
    int          txN = txQ.size();
    int          rxN = rxQ.size();
    bit          isWr = (cmd == SCR1_MEM_CMD_WR);
    bit          err = 0;
    bit          corePush = 0, corePop = 0, fTx = 0, fRx = 0;
    bit          newIrqEn = irqEnModel;
    logic [31:0] rd = 0;
    if (req) begin
      if (width != SCR1_MEM_WIDTH_WORD || addr[1:0] != 2'b00) err = 1;
      else begin
        case (addr[3:2])
          2'd0: if (!isWr || txN == DEPTH) err = 1; else corePush = 1;
          2'd1: if (isWr || rxN == 0) err = 1; else begin corePop = 1; rd = rxQ[0]; end
          2'd2: if (isWr) err = 1;
                else rd = 32'(txN == DEPTH) + 32'(txN == 0) * 2 + 32'(rxN == DEPTH) * 4
                        + 32'(rxN == 0) * 8 + 32'(txN) * 256 + 32'(rxN) * 65536;
          default: if (isWr) begin fTx = wdata[0]; fRx = wdata[1]; newIrqEn = wdata[2]; end
                   else rd = irqEnModel ? 32'd4 : 32'd0;
        endcase
      end
      if (err) rd = 0;
      expErrQ.push_back(err);
      expRdataQ.push_back(rd);
    end
    if (fTx) txQ.delete();
    else begin
      if (txN > 0 && txRdyIn) void'(txQ.pop_front());
      if (corePush) txQ.push_back(wdata);
    end
    if (fRx) rxQ.delete();
    else begin
      if (corePop) void'(rxQ.pop_front());
      if (rxVldIn && rxN < DEPTH) rxQ.push_back(rxDataIn);
    end
    irqEnModel = newIrqEn;
  endtask

  // One cycle: check outputs mid-cycle, then drive inputs and predict
  task automatic applyStimulus(input logic req, input type_scr1_mem_cmd_e cmd,
                               input type_scr1_mem_width_e width, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic txRdyIn,
                               input logic rxVldIn, input logic [31:0] rxDataIn);
    @(negedge clk);
    #1;
    checkOutput();
    mboxIf.dmem_req   = req;
    mboxIf.dmem_cmd   = cmd;
    mboxIf.dmem_width = width;
    mboxIf.dmem_addr  = addr;
    mboxIf.dmem_wdata = wdata;
    txRdy  = txRdyIn;
    rxVld  = rxVldIn;
    rxData = rxDataIn;
    modelStep(req, cmd, width, addr, wdata, txRdyIn, rxVldIn, rxDataIn);
  endtask

  task automatic idle(input logic txRdyIn, input logic rxVldIn, input logic [31:0] rxDataIn);
    applyStimulus(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0, txRdyIn, rxVldIn, rxDataIn);
  endtask

  // Response monitor: every presented response must match the scoreboard head
  bit          monErr;
  logic [31:0] monRdata;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mboxIf.dmem_resp !== SCR1_MEM_RESP_NOTRDY || expErrQ.size() > 0) begin
        if (expErrQ.size() == 0) begin
          checkVal("unexpected_resp", 32'(mboxIf.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        end else begin
          monErr   = expErrQ.pop_front();
          monRdata = expRdataQ.pop_front();
          checkVal("resp", 32'(mboxIf.dmem_resp),
                   monErr ? 32'(SCR1_MEM_RESP_RDY_ER) : 32'(SCR1_MEM_RESP_RDY_OK));
          checkVal("rdata", mboxIf.dmem_rdata, monRdata);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    mboxIf.dmem_req   = 1'b0;
    mboxIf.dmem_cmd   = SCR1_MEM_CMD_RD;
    mboxIf.dmem_width = SCR1_MEM_WIDTH_WORD;
    mboxIf.dmem_addr  = '0;
    mboxIf.dmem_wdata = '0;
    txRdy = 1'b0; rxVld = 1'b0; rxData = '0;
    #23 rst_n = 1'b1;

    // Reset state
    checkVal("reset_resp", 32'(mboxIf.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    checkVal("reset_rdata", mboxIf.dmem_rdata, 32'h0);

    // Single TX write then STATUS
    applyStimulus(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0003_0000, 32'hA5A5_0001, 0, 0, 0);
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0008, 32'h0, 0, 0, 0);

    // Flush TX, then nine writes into an eight-deep FIFO
    applyStimulus(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0003_000C, 32'h1, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      applyStimulus(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0003_0000, 32'hB000_0000 + k, 0, 0, 0);
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0008, 32'h0, 0, 0, 0);
    idle(1, 0, 0);
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0008, 32'h0, 0, 0, 0);

    // RX read while empty, then one accelerator result and a successful read
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0004, 32'h0, 0, 0, 0);
    idle(0, 1, 32'h1234_5678);
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0004, 32'h0, 0, 0, 0);
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0008, 32'h0, 0, 0, 0);

    // Back-to-back STATUS read and TX write
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0008, 32'h0, 1, 0, 0);
    applyStimulus(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0003_0000, 32'hC0DE_0001, 0, 0, 0);

    // Bad width and misaligned access, then flush both with a concurrent RX push
    applyStimulus(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h0003_0000, 32'hDEAD_0001, 0, 0, 0);
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0002, 32'h0, 0, 0, 0);
    idle(0, 1, 32'h0000_0042);
    applyStimulus(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0003_000C, 32'h3, 0, 1, 32'h0000_0099);
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0008, 32'h0, 0, 0, 0);

    // Interrupt enable, RX word arrives, then popped
    applyStimulus(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0003_000C, 32'h4, 0, 0, 0);
    idle(0, 1, 32'h5555_AAAA);
    idle(0, 0, 0);
    idle(0, 0, 0);
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0004, 32'h0, 0, 0, 0);
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_000C, 32'h0, 0, 0, 0);
    idle(0, 1, 32'h7777_0001);
    idle(0, 0, 0);

    // Reset asserted with a response pending
    applyStimulus(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0003_0008, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkVal("rst_resp", 32'(mboxIf.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
    checkVal("rst_rdata", mboxIf.dmem_rdata, 32'h0);
    checkVal("rst_tx_vld", 32'(txVld), 32'd0);
    checkVal("rst_rx_rdy", 32'(rxRdy), 32'd1);
    checkVal("rst_irq", 32'(irq), 32'd0);
    expErrQ.delete(); expRdataQ.delete(); txQ.delete(); rxQ.delete();
    irqEnModel = 0; prevIrqCond = 0;
    mboxIf.dmem_req = 1'b0; txRdy = 1'b0; rxVld = 1'b0;
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Randomised traffic with alternating fill/drain phases
    for (int i = 0; i < 3000; i++) begin
      logic                 req, tr, rv, phase0;
      logic [31:0]          addr, wdata, rnd, rdat;
      type_scr1_mem_cmd_e   cmd;
      type_scr1_mem_width_e width;
      int                   sel, wsel;
      phase0 = ((i / 400) % 2) == 0;
      req  = ($urandom_range(0, 3) != 0);
      cmd  = ($urandom_range(0, 1) != 0) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
      wsel = $urandom_range(0, 15);
      width = (wsel == 0) ? SCR1_MEM_WIDTH_BYTE :
              (wsel == 1) ? SCR1_MEM_WIDTH_HWORD : SCR1_MEM_WIDTH_WORD;
      sel  = (phase0 && $urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 3);
      if (phase0 && sel == 0) cmd = SCR1_MEM_CMD_WR;
      rnd  = $urandom;
      addr = {rnd[31:4], 4'h0} | 32'(sel * 4);
      if ($urandom_range(0, 15) == 0) addr[1:0] = rnd[1:0];
      wdata = $urandom;
      if (sel == 3 && $urandom_range(0, 7) != 0) wdata[1:0] = 2'b00;
      tr   = phase0 ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) != 0);
      rv   = phase0 ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) == 0);
      rdat = $urandom;
      applyStimulus(req, cmd, width, addr, wdata, tr, rv, rdat);
    end

    idle(0, 0, 0);
    idle(0, 0, 0);
    idle(0, 0, 0);
    checkVal("drain", 32'(expErrQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
